// File: rtl/seq_mult8.sv
// Sequential unsigned shift-and-add multiplier: one WIDTH-bit add with carry-out
// per iteration, WIDTH iterations per product, one-cycle done pulse on completion.
module seq_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     hi_q, lo_q, mcand_q;
  logic [CW-1:0]        count_q;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH:0]       add_d;
  logic [WIDTH-1:0]     hi_d, lo_d;

  // {carry, sum, lo} shifted right by one: the carry lands in hi's MSB.
  always_comb begin
    add_d = {1'b0, hi_q};
    if (lo_q[0]) begin
      add_d = {1'b0, hi_q} + {1'b0, mcand_q};
    end
    hi_d = add_d[WIDTH:1];
    lo_d = {add_d[0], lo_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= A;
            hi_q    <= '0;
            lo_q    <= B;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (count_q == LAST) begin
            product_q <= {hi_d, lo_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule
